// File: rtl/idma_nd_arb_pkg.sv
// Shared types for the ND request arbiter.
package idma_nd_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/idma_nd_arbiter_fifo_v3.sv
// fifo_v3: first-word-registered FIFO holding the owner of each in-flight ND transfer.
// Reset input rst_ni is sampled synchronously so the whole arbiter shares one reset style.
module fifo_v3 #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 8,
  parameter type         dtype      = logic [DATA_WIDTH-1:0],
  parameter int unsigned ADDR_DEPTH = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic flush_i,
  output logic full_o,
  output logic empty_o,
  input  dtype data_i,
  input  logic push_i,
  output dtype data_o,
  input  logic pop_i
);

  localparam int unsigned FifoDepth = (DEPTH > 0) ? DEPTH : 1;

  logic [ADDR_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_DEPTH:0]   cnt_q, cnt_d;
  logic                  do_push, do_pop;
  dtype                  mem_q [FifoDepth];

  function automatic logic [ADDR_DEPTH-1:0] ptr_inc(input logic [ADDR_DEPTH-1:0] p);
    return (p == ADDR_DEPTH'(FifoDepth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (cnt_q == (ADDR_DEPTH + 1)'(FifoDepth));
  assign empty_o = (cnt_q == '0);
  assign data_o  = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o & ~flush_i;
  assign do_pop  = pop_i & ~empty_o & ~flush_i;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage carries data only; it needs no reset.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/idma_nd_arbiter.sv
// Round-robin arbiter letting several ND requesters share one ND midend, routing responses back in order.
// Optional macro IDMA_ND_ARB_PRIO_EN adds prio_i: prioritised requesters are arbitrated first.
module idma_nd_arbiter
  import idma_nd_arb_pkg::*;
#(
  parameter int unsigned NumPorts       = 2,
  parameter int unsigned MaxOutstanding = 4,
  parameter type         idma_nd_req_t  = logic,
  parameter type         idma_rsp_t     = logic
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  idma_nd_req_t        req_i [NumPorts],
  input  logic [NumPorts-1:0] req_valid_i,
  output logic [NumPorts-1:0] req_ready_o,
  output idma_rsp_t           rsp_o [NumPorts],
  output logic [NumPorts-1:0] rsp_valid_o,
  input  logic [NumPorts-1:0] rsp_ready_i,
`ifdef IDMA_ND_ARB_PRIO_EN
  input  logic [NumPorts-1:0] prio_i,
`endif
  output idma_nd_req_t        nd_req_o,
  output logic                nd_req_valid_o,
  input  logic                nd_req_ready_i,
  input  idma_rsp_t           nd_rsp_i,
  input  logic                nd_rsp_valid_i,
  output logic                nd_rsp_ready_o,
  output logic                busy_o
);

  localparam int unsigned IdxW = (NumPorts > 1) ? $clog2(NumPorts) : 1;

  arb_state_e          state_q, state_d;
  logic [IdxW-1:0]     owner_q, owner_d;
  logic [IdxW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [NumPorts-1:0] cand;
  logic [IdxW-1:0]     winner;
  logic                found;
  logic                push, pop;
  logic                fifo_full, fifo_empty;
  logic [IdxW-1:0]     head;

`ifdef IDMA_ND_ARB_PRIO_EN
  assign cand = (|(req_valid_i & prio_i)) ? (req_valid_i & prio_i) : req_valid_i;
`else
  assign cand = req_valid_i;
`endif

  // First candidate at or after rr_ptr_q, wrapping around.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int unsigned i = 0; i < NumPorts; i++) begin
      if (!found && cand[IdxW'((32'(rr_ptr_q) + i) % NumPorts)]) begin
        found  = 1'b1;
        winner = IdxW'((32'(rr_ptr_q) + i) % NumPorts);
      end
    end
  end

  always_comb begin
    req_ready_o    = '0;
    rsp_valid_o    = '0;
    nd_req_valid_o = 1'b0;
    nd_rsp_ready_o = 1'b0;
    busy_o         = 1'b0;
    nd_req_o       = req_i[owner_q];
    for (int unsigned k = 0; k < NumPorts; k++) rsp_o[k] = nd_rsp_i;
    if (!rst_i) begin
      if (state_q == LOCKED) begin
        nd_req_valid_o       = req_valid_i[owner_q];
        req_ready_o[owner_q] = nd_req_ready_i;
      end
      if (!fifo_empty) begin
        rsp_valid_o[head] = nd_rsp_valid_i;
        nd_rsp_ready_o    = rsp_ready_i[head];
      end
      busy_o = (state_q == LOCKED) | ~fifo_empty;
    end
  end

  assign pop = nd_rsp_valid_i & nd_rsp_ready_o;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    push     = 1'b0;
    case (state_q)
      IDLE: begin
        if (found && !fifo_full) begin
          owner_d = winner;
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        // The midend only raises ready on the last burst, so the grant is held until then.
        if (nd_req_valid_o && nd_req_ready_i) begin
          push     = 1'b1;
          rr_ptr_d = (owner_q == IdxW'(NumPorts - 1)) ? '0 : owner_q + 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  fifo_v3 #(
    .DATA_WIDTH (IdxW),
    .DEPTH      (MaxOutstanding)
  ) i_owner_fifo (
    .clk_i   (clk_i),
    .rst_ni  (~rst_i),
    .flush_i (1'b0),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .data_i  (owner_q),
    .push_i  (push),
    .data_o  (head),
    .pop_i   (pop)
  );

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (state_q == LOCKED) assert (req_valid_i[owner_q]);
      if (fifo_empty) assert (!nd_rsp_valid_i);
    end
  end
`endif

endmodule

// File: tb/tb_idma_nd_arbiter.sv
// Directed bench for idma_nd_arbiter (4 ports, 2 outstanding); prio case runs when IDMA_ND_ARB_PRIO_EN is defined.
module tb_idma_nd_arbiter;

  typedef logic [7:0] req_t;
  typedef logic [7:0] rsp_t;

  logic       clk = 1'b0;
  logic       rst;
  req_t       req [4];
  logic [3:0] req_valid, req_ready;
  rsp_t       rsp [4];
  logic [3:0] rsp_valid, rsp_ready;
  req_t       nd_req;
  logic       nd_req_valid, nd_req_ready;
  rsp_t       nd_rsp;
  logic       nd_rsp_valid, nd_rsp_ready, busy;
`ifdef IDMA_ND_ARB_PRIO_EN
  logic [3:0] prio;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  idma_nd_arbiter #(
    .NumPorts       (4),
    .MaxOutstanding (2),
    .idma_nd_req_t  (req_t),
    .idma_rsp_t     (rsp_t)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .req_i          (req),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .rsp_o          (rsp),
    .rsp_valid_o    (rsp_valid),
    .rsp_ready_i    (rsp_ready),
`ifdef IDMA_ND_ARB_PRIO_EN
    .prio_i         (prio),
`endif
    .nd_req_o       (nd_req),
    .nd_req_valid_o (nd_req_valid),
    .nd_req_ready_i (nd_req_ready),
    .nd_rsp_i       (nd_rsp),
    .nd_rsp_valid_i (nd_rsp_valid),
    .nd_rsp_ready_o (nd_rsp_ready),
    .busy_o         (busy)
  );

  typedef struct {
    logic [3:0] v;
    logic       ndr;
    logic       rv;
    logic [3:0] rr;
    logic       e_ndv;
    logic [3:0] e_rdy;
    logic [3:0] e_rspv;
    logic       e_ndrr;
    logic       e_busy;
    int         e_own;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [3:0] v, input logic ndr,
                       input logic rv, input logic [3:0] rr);
    @(negedge clk);
    rst          = r;
    req_valid    = v;
    nd_req_ready = ndr;
    nd_rsp_valid = rv;
    rsp_ready    = rr;
    #1;
  endtask

  task automatic chk_all(input string tag, input logic ndv, input logic [3:0] rdy,
                         input logic [3:0] rspv, input logic ndrr, input logic bsy);
    chk({tag, ".nd_req_valid"}, 32'(nd_req_valid), 32'(ndv));
    chk({tag, ".req_ready"},    32'(req_ready),    32'(rdy));
    chk({tag, ".rsp_valid"},    32'(rsp_valid),    32'(rspv));
    chk({tag, ".nd_rsp_ready"}, 32'(nd_rsp_ready), 32'(ndrr));
    chk({tag, ".busy"},         32'(busy),         32'(bsy));
  endtask

  initial begin
    #100000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    for (int k = 0; k < 4; k++) req[k] = 8'h10 + 8'(k);
    rst = 1'b1; req_valid = 4'b0011; nd_req_ready = 1'b0;
    nd_rsp_valid = 1'b0; rsp_ready = 4'b1111; nd_rsp = 8'h00;
`ifdef IDMA_ND_ARB_PRIO_EN
    prio = 4'b0000;
`endif

    //            v       ndr   rv    rr      ndv   rdy     rspv    ndrr  busy  own
    tbl[0]  = '{4'b0011, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, -1};
    tbl[1]  = '{4'b0011, 1'b0, 1'b0, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b1, 0};
    tbl[2]  = '{4'b0011, 1'b0, 1'b0, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b1, 0};
    tbl[3]  = '{4'b0011, 1'b1, 1'b0, 4'b0000, 1'b1, 4'b0001, 4'b0000, 1'b0, 1'b1, 0};
    tbl[4]  = '{4'b0011, 1'b0, 1'b0, 4'b1111, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b1, -1};
    tbl[5]  = '{4'b0011, 1'b0, 1'b1, 4'b1111, 1'b1, 4'b0000, 4'b0001, 1'b1, 1'b1, 1};
    tbl[6]  = '{4'b0011, 1'b0, 1'b0, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b1, 1};
    tbl[7]  = '{4'b0011, 1'b1, 1'b0, 4'b0000, 1'b1, 4'b0010, 4'b0000, 1'b0, 1'b1, 1};
    tbl[8]  = '{4'b0011, 1'b0, 1'b1, 4'b0010, 1'b0, 4'b0000, 4'b0010, 1'b1, 1'b1, -1};
    tbl[9]  = '{4'b0011, 1'b1, 1'b0, 4'b0000, 1'b1, 4'b0001, 4'b0000, 1'b0, 1'b1, 0};
    tbl[10] = '{4'b0011, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, -1};
    tbl[11] = '{4'b0011, 1'b1, 1'b1, 4'b0001, 1'b1, 4'b0010, 4'b0001, 1'b1, 1'b1, 1};
    tbl[12] = '{4'b0000, 1'b0, 1'b1, 4'b0010, 1'b0, 4'b0000, 4'b0010, 1'b1, 1'b1, -1};
    tbl[13] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, -1};

    drive(1'b1, 4'b0011, 1'b1, 1'b0, 4'b1111);
    chk_all("reset0", 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);
    drive(1'b1, 4'b0011, 1'b1, 1'b0, 4'b1111);
    chk_all("reset1", 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);

    // Alternating grants, in-order response routing, simultaneous push/pop.
    for (int i = 0; i < 14; i++) begin
      nd_rsp = 8'hC0 + 8'(i);
      drive(1'b0, tbl[i].v, tbl[i].ndr, tbl[i].rv, tbl[i].rr);
      chk_all($sformatf("row%0d", i), tbl[i].e_ndv, tbl[i].e_rdy, tbl[i].e_rspv,
              tbl[i].e_ndrr, tbl[i].e_busy);
      chk($sformatf("row%0d.rsp_o", i), 32'(rsp[i % 4]), 32'(8'hC0 + 8'(i)));
      if (tbl[i].e_own >= 0)
        chk($sformatf("row%0d.nd_req_o", i), 32'(nd_req), 32'(req[tbl[i].e_own]));
    end

    // Fill to MaxOutstanding, hold the response back, then release one.
    drive(1'b0, 4'b1000, 1'b1, 1'b0, 4'b0000);
    chk("full.a0.nd_req_valid", 32'(nd_req_valid), 32'd0);
    drive(1'b0, 4'b1000, 1'b1, 1'b0, 4'b0000);
    chk_all("full.a1", 1'b1, 4'b1000, 4'b0000, 1'b0, 1'b1);
    drive(1'b0, 4'b1000, 1'b1, 1'b0, 4'b0000);
    drive(1'b0, 4'b1000, 1'b1, 1'b0, 4'b0000);
    chk_all("full.a3", 1'b1, 4'b1000, 4'b0000, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 4'b1000, 1'b1, 1'b0, 4'b0000);
      chk_all($sformatf("full.hold%0d", i), 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1);
    end
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 4'b1000, 1'b1, 1'b1, 4'b0111);
      chk_all($sformatf("stall%0d", i), 1'b0, 4'b0000, 4'b1000, 1'b0, 1'b1);
    end
    drive(1'b0, 4'b1000, 1'b1, 1'b1, 4'b1000);
    chk_all("full.pop", 1'b0, 4'b0000, 4'b1000, 1'b1, 1'b1);
    drive(1'b0, 4'b1000, 1'b1, 1'b0, 4'b0000);
    chk_all("full.after_pop", 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1);
    drive(1'b0, 4'b1000, 1'b1, 1'b0, 4'b0000);
    chk_all("full.regrant", 1'b1, 4'b1000, 4'b0000, 1'b0, 1'b1);
    drive(1'b0, 4'b0000, 1'b0, 1'b1, 4'b1111);
    chk("full.drain0", 32'(rsp_valid), 32'(4'b1000));
    drive(1'b0, 4'b0000, 1'b0, 1'b1, 4'b1111);
    chk("full.drain1", 32'(rsp_valid), 32'(4'b1000));
    drive(1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000);
    chk("full.idle.busy", 32'(busy), 32'd0);

    // Reset while LOCKED with one transfer outstanding.
    drive(1'b0, 4'b0001, 1'b1, 1'b0, 4'b0000);
    drive(1'b0, 4'b0001, 1'b1, 1'b0, 4'b0000);
    chk_all("rst.b1", 1'b1, 4'b0001, 4'b0000, 1'b0, 1'b1);
    drive(1'b0, 4'b0011, 1'b0, 1'b0, 4'b0000);
    drive(1'b0, 4'b0011, 1'b0, 1'b0, 4'b0000);
    chk("rst.b3.nd_req_o", 32'(nd_req), 32'(req[1]));
    chk_all("rst.b3", 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b1);
    drive(1'b1, 4'b0011, 1'b0, 1'b0, 4'b1111);
    chk_all("rst.during", 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);
    drive(1'b0, 4'b0011, 1'b0, 1'b0, 4'b1111);
    chk_all("rst.after", 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);
    drive(1'b0, 4'b0011, 1'b1, 1'b0, 4'b0000);
    chk("rst.regrant.nd_req_o", 32'(nd_req), 32'(req[0]));
    chk_all("rst.regrant", 1'b1, 4'b0001, 4'b0000, 1'b0, 1'b1);
    drive(1'b0, 4'b0000, 1'b0, 1'b1, 4'b1111);
    chk("rst.rsp_valid", 32'(rsp_valid), 32'(4'b0001));
    drive(1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000);
    chk("rst.end.busy", 32'(busy), 32'd0);

`ifdef IDMA_ND_ARB_PRIO_EN
    // Prioritised port 2 keeps winning over port 0 until it drops.
    prio = 4'b0100;
    drive(1'b0, 4'b0101, 1'b1, 1'b0, 4'b0000);
    drive(1'b0, 4'b0101, 1'b1, 1'b0, 4'b0000);
    chk("prio.g0", 32'(nd_req), 32'(req[2]));
    drive(1'b0, 4'b0101, 1'b1, 1'b1, 4'b1111);
    chk("prio.rsp0", 32'(rsp_valid), 32'(4'b0100));
    drive(1'b0, 4'b0101, 1'b1, 1'b0, 4'b0000);
    chk("prio.g1", 32'(nd_req), 32'(req[2]));
    drive(1'b0, 4'b0001, 1'b1, 1'b1, 4'b1111);
    chk("prio.rsp1", 32'(rsp_valid), 32'(4'b0100));
    drive(1'b0, 4'b0001, 1'b1, 1'b0, 4'b0000);
    chk("prio.g2", 32'(nd_req), 32'(req[0]));
    chk("prio.g2.valid", 32'(nd_req_valid), 32'd1);
    drive(1'b0, 4'b0000, 1'b0, 1'b1, 4'b1111);
    chk("prio.rsp2", 32'(rsp_valid), 32'(4'b0001));
    drive(1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000);
    chk("prio.end.busy", 32'(busy), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/idma_nd_arbiter.md
IDMA_ND_ARBITER -- requirements
Module: idma_nd_arbiter

Interface
REQ-001 SHALL have parameter NumPorts, default 2: number of ND requesters sharing one ND midend.
REQ-002 SHALL have parameter MaxOutstanding, default 4: number of accepted ND transfers awaiting final response.
REQ-003 SHALL have parameter type idma_nd_req_t, default logic: ND request type.
REQ-004 SHALL have parameter type idma_rsp_t, default logic: iDMA response type.
REQ-005 SHALL have port clk_i, input, 1: the single clock.
REQ-006 SHALL have port rst_i, input, 1: reset, synchronous, active-high.
REQ-007 SHALL have port req_i, input, NumPorts x idma_nd_req_t: per-requester ND request.
REQ-008 SHALL have port req_valid_i, input, NumPorts: per-requester valid.
REQ-009 SHALL have port req_ready_o, output, NumPorts: per-requester ready.
REQ-010 SHALL have port rsp_o, output, NumPorts x idma_rsp_t: per-requester response.
REQ-011 SHALL have port rsp_valid_o, output, NumPorts: per-requester response valid.
REQ-012 SHALL have port rsp_ready_i, input, NumPorts: per-requester response ready.
REQ-013 SHALL have port nd_req_o, output, idma_nd_req_t: request to midend.
REQ-014 SHALL have port nd_req_valid_o, output, 1: valid to midend.
REQ-015 SHALL have port nd_req_ready_i, input, 1: midend ready, which pulses only on the last burst of an ND transfer.
REQ-016 SHALL have port nd_rsp_i, input, idma_rsp_t: response from midend.
REQ-017 SHALL have port nd_rsp_valid_i, input, 1: midend response valid, one per ND transfer.
REQ-018 SHALL have port nd_rsp_ready_o, output, 1: ready to midend.
REQ-019 SHALL have port busy_o, output, 1: arbiter is locked or has outstanding transfers.

Function
REQ-020 SHALL implement FSM states IDLE and LOCKED.
REQ-021 In IDLE, SHALL register the round-robin winner among asserted req_valid_i, starting the search at rr_ptr, and enter LOCKED next cycle, only if outstanding count < MaxOutstanding.
REQ-022 In LOCKED, SHALL drive nd_req_o = req_i[owner] and nd_req_valid_o = req_valid_i[owner], and SHALL assert req_ready_o[owner] = nd_req_ready_i; all other req_ready_o SHALL be 0.
REQ-023 On the nd_req handshake, SHALL push owner into the owner FIFO, set rr_ptr = (owner+1) mod NumPorts, and return to IDLE.
REQ-024 Latency from req_valid_i rising in IDLE to nd_req_valid_o SHALL be exactly 1 cycle; back-to-back grants SHALL be separated by one IDLE cycle.
REQ-025 Grant SHALL hold while the midend iterates; a requester deasserting valid while LOCKED is a protocol violation, flagged by a nonsynth assertion.
REQ-026 rsp_o[k] SHALL equal nd_rsp_i for all k; rsp_valid_o[head] SHALL equal nd_rsp_valid_i, and all other bits SHALL be 0.
REQ-027 nd_rsp_ready_o SHALL equal rsp_ready_i[head]; the FIFO SHALL pop on the response handshake.
REQ-028 With the FIFO empty, nd_rsp_ready_o and all rsp_valid_o SHALL be 0, and nd_rsp_valid_i SHALL trigger an assertion.
REQ-029 A push and a pop in the same cycle SHALL leave the count unchanged.
REQ-030 At full (count == MaxOutstanding), no grant SHALL occur; IDLE persists until a pop.
REQ-031 rr_ptr SHALL wrap from NumPorts-1 to 0.
REQ-032 busy_o SHALL be (state == LOCKED) | (count != 0).

Reset
REQ-033 With rst_i high at a clock edge, SHALL go to IDLE, set rr_ptr = 0, and empty the FIFO, including mid-transfer.
REQ-034 During reset, every output (valids, readies, busy_o) SHALL be 0, and data outputs SHALL be don't-care.

Configuration
REQ-035 Macro IDMA_ND_ARB_PRIO_EN defined SHALL add input prio_i, NumPorts wide; in IDLE, requesters with valid & prio SHALL be arbitrated round-robin first, and the others only when none qualify.
REQ-036 Macro IDMA_ND_ARB_PRIO_EN undefined SHALL leave prio_i absent and apply pure round-robin.

Structure
REQ-037 Package idma_nd_arb_pkg SHALL hold the FSM state enum (IDLE, LOCKED).
REQ-038 The port index width SHALL be a localparam: $clog2(NumPorts) with a minimum of 1.
REQ-039 The owner FIFO SHALL be the common_cells fifo_v3 sub-module (depth MaxOutstanding, data width = index width); no other sub-module is used.

Verification
REQ-040 Ports 0 and 1 valid continuously, midend accepts after 3 cycles -> grants alternate 0,1,0,1; responses are routed to the matching port in order.
REQ-041 MaxOutstanding = 2, responses withheld -> 2 transfers are accepted, the third stays ungranted with busy_o = 1; a single response -> the third is granted 1 cycle later.
REQ-042 Response handshake in the same cycle as a new nd_req handshake -> count unchanged; the FIFO head advances correctly.
REQ-043 rst_i asserted while LOCKED with 1 outstanding -> next cycle all valid/ready outputs and busy_o are 0; the next request goes to port 0 from rr_ptr = 0.
REQ-044 IDMA_ND_ARB_PRIO_EN defined, NumPorts = 4, ports 0 and 2 valid, prio_i = 4'b0100 -> port 2 is granted repeatedly while it stays valid; port 0 is granted after port 2 drops.
REQ-045 rsp_ready_i[owner] = 0 for 5 cycles -> nd_rsp_ready_o stays 0 and rsp_valid_o holds on the owner only.
